// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state codes and constants for the mm:ss timer
package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int   MAX_VAL_DEF = 59;
  localparam logic DIR_UP      = 1'b1;
  localparam logic DIR_DOWN    = 1'b0;

endpackage

// File: rtl/mod60_counter.sv
// rtl/mod60_counter.sv - wrapping 0..MAX_VAL field register with up/down step and preset increment
module mod60_counter
  import timer_pkg::*;
#(
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       inc,
  output logic [5:0] value,
  output logic       carry,
  output logic       borrow
);

  localparam logic [5:0] TOP = 6'(MAX_VAL);

  logic [5:0] plus_one;
  logic [5:0] minus_one;

  always_comb begin
    plus_one  = (value >= TOP) ? 6'd0 : value + 6'd1;
    minus_one = (value == 6'd0) ? TOP : value - 6'd1;
  end

  // Preset increment outranks the step so IDLE presets never depend on direction.
  always_ff @(posedge clk_1Hz) begin
    if (reset || clr) begin
      value <= 6'd0;
    end else if (inc) begin
      value <= plus_one;
    end else if (en) begin
      value <= up ? plus_one : minus_one;
    end
  end

  assign carry  = up && (value == TOP);
  assign borrow = !up && (value == 6'd0);

endmodule

// File: rtl/timer_ctrl_fsm.sv
// rtl/timer_ctrl_fsm.sv - stopwatch/countdown sequencer owning the mm:ss registers and alarm timing
module timer_ctrl_fsm
  import timer_pkg::*;
#(
  parameter int MAX_VAL      = MAX_VAL_DEF,
  parameter int ALARM_CYCLES = 10
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       mode,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       inc_sec,
  input  logic       inc_min,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [1:0] state,
  output logic       running,
  output logic       finish,
  output logic       alarm
);

  localparam int            AW         = $clog2(ALARM_CYCLES + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

  state_t        cur;
  state_t        nxt;
  logic          dir;
  logic          dir_nxt;
  logic [AW-1:0] alarm_cnt;
  logic          clr_all;
  logic          step;
  logic          sec_inc;
  logic          min_inc;
  logic          sec_carry;
  logic          sec_borrow;
  logic          min_borrow;
  logic          unused_min_carry;
  logic          is_zero;
  logic          last_step;

  assign is_zero   = (seconds == 6'd0) && (minutes == 6'd0);
  // 00:01 counting down: this step lands on 00:00.
  assign last_step = (seconds == 6'd1) && min_borrow;

  always_comb begin
    nxt     = cur;
    dir_nxt = dir;
    clr_all = 1'b0;
    step    = 1'b0;
    sec_inc = 1'b0;
    min_inc = 1'b0;
    case (cur)
      S_IDLE: begin
        if (clear) begin
          clr_all = 1'b1;
        end else if (!stop) begin
          if (start && (mode == DIR_UP)) begin
            clr_all = 1'b1;
            dir_nxt = DIR_UP;
            nxt     = S_RUN;
          end else if (start && !is_zero) begin
            dir_nxt = DIR_DOWN;
            nxt     = S_RUN;
          end else if (mode == DIR_DOWN) begin
            sec_inc = inc_sec;
            min_inc = inc_min;
          end
        end
      end
      S_RUN: begin
        if (clear) begin
          clr_all = 1'b1;
          nxt     = S_IDLE;
        end else if (stop) begin
          nxt = S_PAUSE;
        end else begin
          step = 1'b1;
          if (last_step) nxt = S_DONE;
        end
      end
      S_PAUSE: begin
        if (clear) begin
          clr_all = 1'b1;
          nxt     = S_IDLE;
        end else if (!stop && start) begin
          nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (clear || (start && !stop) || (alarm_cnt == ALARM_LAST)) begin
          clr_all = clear;
          nxt     = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      cur       <= S_IDLE;
      dir       <= DIR_UP;
      alarm_cnt <= '0;
      running   <= 1'b0;
      finish    <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      cur       <= nxt;
      dir       <= dir_nxt;
      alarm_cnt <= ((cur == S_DONE) && (nxt == S_DONE)) ? alarm_cnt + 1'b1 : '0;
      running   <= (nxt == S_RUN);
      finish    <= (cur == S_RUN) && (nxt == S_DONE);
      alarm     <= (nxt == S_DONE);
    end
  end

  assign state = cur;

  mod60_counter #(.MAX_VAL(MAX_VAL)) u_sec (
    .clk_1Hz (clk_1Hz),
    .reset   (reset),
    .en      (step),
    .up      (dir),
    .clr     (clr_all),
    .inc     (sec_inc),
    .value   (seconds),
    .carry   (sec_carry),
    .borrow  (sec_borrow)
  );

  mod60_counter #(.MAX_VAL(MAX_VAL)) u_min (
    .clk_1Hz (clk_1Hz),
    .reset   (reset),
    .en      (step && (sec_carry || sec_borrow)),
    .up      (dir),
    .clr     (clr_all),
    .inc     (min_inc),
    .value   (minutes),
    .carry   (unused_min_carry),
    .borrow  (min_borrow)
  );

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// tb/tb_timer_ctrl_fsm.sv - table, directed and random checks of timer_ctrl_fsm against a reference model
module tb_timer_ctrl_fsm;

  localparam logic [6:0] I_RST = 7'b1000000;
  localparam logic [6:0] I_CLR = 7'b0100000;
  localparam logic [6:0] I_STP = 7'b0010000;
  localparam logic [6:0] I_STA = 7'b0001000;
  localparam logic [6:0] I_MD  = 7'b0000100;
  localparam logic [6:0] I_SEC = 7'b0000010;
  localparam logic [6:0] I_MIN = 7'b0000001;

  logic       clk_1Hz = 1'b0;
  logic       reset, mode, start, stop, clear, inc_sec, inc_min;
  logic [5:0] seconds, minutes;
  logic [1:0] state;
  logic       running, finish, alarm;
  logic [16:0] dut_vec;

  int errors = 0;
  int checks = 0;

  // Reference model: time kept as plain field values, steps done on total seconds.
  int m_st, m_ss, m_mm, m_acnt;
  bit m_up, m_run, m_fin, m_alarm;

  typedef struct {
    logic [6:0]  in;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk_1Hz = ~clk_1Hz;

  timer_ctrl_fsm #(.MAX_VAL(59), .ALARM_CYCLES(10)) dut (
    .clk_1Hz (clk_1Hz),
    .reset   (reset),
    .mode    (mode),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .inc_sec (inc_sec),
    .inc_min (inc_min),
    .seconds (seconds),
    .minutes (minutes),
    .state   (state),
    .running (running),
    .finish  (finish),
    .alarm   (alarm)
  );

  assign dut_vec = {seconds, minutes, state, running, finish, alarm};

  function automatic logic [16:0] model_vec();
    return {6'(m_ss), 6'(m_mm), 2'(m_st), m_run, m_fin, m_alarm};
  endfunction

  function automatic vec_t mk(input logic [6:0] in, input int s, input int m, input int st,
                              input logic [2:0] o);
    vec_t r;
    r.in  = in;
    r.exp = {6'(s), 6'(m), 2'(st), o};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [6:0] in);
    bit rst, clr, stp, sta, md, isec, imin;
    int tot;
    {rst, clr, stp, sta, md, isec, imin} = in;
    m_fin = 1'b0;
    if (rst) begin
      m_st = 0; m_ss = 0; m_mm = 0; m_up = 1'b1; m_acnt = 0;
    end else begin
      case (m_st)
        0: begin
          if (clr) begin
            m_ss = 0; m_mm = 0;
          end else if (!stp) begin
            if (sta && md) begin
              m_ss = 0; m_mm = 0; m_up = 1'b1; m_st = 1;
            end else if (sta && (m_ss + m_mm) != 0) begin
              m_up = 1'b0; m_st = 1;
            end else if (!md) begin
              if (isec) m_ss = (m_ss + 1) % 60;
              if (imin) m_mm = (m_mm + 1) % 60;
            end
          end
        end
        1: begin
          if (clr) begin
            m_ss = 0; m_mm = 0; m_st = 0;
          end else if (stp) begin
            m_st = 2;
          end else begin
            tot  = m_mm * 60 + m_ss;
            tot  = m_up ? (tot + 1) % 3600 : tot - 1;
            m_mm = tot / 60;
            m_ss = tot % 60;
            if (!m_up && tot == 0) begin
              m_st = 3; m_fin = 1'b1; m_acnt = 1;
            end
          end
        end
        2: begin
          if (clr) begin
            m_ss = 0; m_mm = 0; m_st = 0;
          end else if (!stp && sta) begin
            m_st = 1;
          end
        end
        default: begin
          if (clr || (sta && !stp) || m_acnt == 10) m_st = 0;
          else m_acnt++;
        end
      endcase
    end
    m_run   = (m_st == 1);
    m_alarm = (m_st == 3);
  endtask

  task automatic tick(input logic [6:0] in);
    {reset, clear, stop, start, mode, inc_sec, inc_min} = in;
    @(posedge clk_1Hz);
    model_edge(in);
    @(negedge clk_1Hz);
    check("model", 32'(dut_vec), 32'(model_vec()));
  endtask

  initial begin
    int not_run;
    int fin_seen;
    logic [6:0] r;

    {reset, clear, stop, start, mode, inc_sec, inc_min} = 7'b1000000;
    m_st = 0; m_ss = 0; m_mm = 0; m_acnt = 0;
    m_up = 1'b1; m_run = 1'b0; m_fin = 1'b0; m_alarm = 1'b0;

    // Outputs {run, finish, alarm} in the last field.
    tbl.push_back(mk(I_RST,         0, 0, 0, 3'b000));
    tbl.push_back(mk(I_SEC,         1, 0, 0, 3'b000));
    tbl.push_back(mk(I_SEC,         2, 0, 0, 3'b000));
    tbl.push_back(mk(I_STA,         2, 0, 1, 3'b100));
    tbl.push_back(mk(7'b0,          1, 0, 1, 3'b100));
    tbl.push_back(mk(7'b0,          0, 0, 3, 3'b011));
    for (int i = 0; i < 9; i++) tbl.push_back(mk(7'b0, 0, 0, 3, 3'b001));
    tbl.push_back(mk(7'b0,          0, 0, 0, 3'b000));
    tbl.push_back(mk(I_STA | I_STP, 0, 0, 0, 3'b000));
    tbl.push_back(mk(I_STA,         0, 0, 0, 3'b000));
    tbl.push_back(mk(I_STA | I_STP | I_MD, 0, 0, 0, 3'b000));
    tbl.push_back(mk(I_STA | I_MD,  0, 0, 1, 3'b100));
    tbl.push_back(mk(7'b0,          1, 0, 1, 3'b100));
    tbl.push_back(mk(I_STP,         1, 0, 2, 3'b000));
    tbl.push_back(mk(I_MIN,         1, 0, 2, 3'b000));
    tbl.push_back(mk(I_STA,         1, 0, 1, 3'b100));
    tbl.push_back(mk(7'b0,          2, 0, 1, 3'b100));
    tbl.push_back(mk(I_CLR,         0, 0, 0, 3'b000));
    tbl.push_back(mk(I_SEC,         1, 0, 0, 3'b000));
    tbl.push_back(mk(I_STA,         1, 0, 1, 3'b100));
    tbl.push_back(mk(7'b0,          0, 0, 3, 3'b011));
    tbl.push_back(mk(I_STA,         0, 0, 0, 3'b000));
    tbl.push_back(mk(7'b0,          0, 0, 0, 3'b000));

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].in);
      check($sformatf("table[%0d]", i), 32'(dut_vec), 32'(tbl[i].exp));
    end

    // Stopwatch across a full hour, toggling mode while running.
    tick(I_RST);
    tick(I_MD | I_STA);
    not_run  = 0;
    fin_seen = 0;
    for (int i = 1; i <= 3600; i++) begin
      tick((i % 2) ? 7'b0 : I_MD);
      if (!running) not_run++;
      if (finish) fin_seen++;
      if (i == 59)   check("up_00_59", 32'({seconds, minutes}), 32'({6'd59, 6'd0}));
      if (i == 60)   check("up_01_00", 32'({seconds, minutes}), 32'({6'd0, 6'd1}));
      if (i == 3599) check("up_59_59", 32'({seconds, minutes}), 32'({6'd59, 6'd59}));
      if (i == 3600) check("up_wrap",  32'({seconds, minutes}), 32'({6'd0, 6'd0}));
    end
    check("up_running_drops", 32'(not_run), 32'd0);
    check("up_finish_pulses", 32'(fin_seen), 32'd0);

    // Countdown from 01:00 with a pause at 00:57.
    tick(I_RST);
    tick(I_MIN);
    tick(I_STA);
    check("cd_start_hold", 32'({seconds, minutes}), 32'({6'd0, 6'd1}));
    tick(7'b0);
    check("cd_first_step", 32'({seconds, minutes}), 32'({6'd59, 6'd0}));
    tick(7'b0);
    tick(7'b0);
    tick(I_STP);
    check("cd_pause_state", 32'({state, seconds}), 32'({2'd2, 6'd57}));
    for (int k = 0; k < 5; k++) begin
      tick((k == 2) ? I_MIN : 7'b0);
      check($sformatf("cd_pause_hold%0d", k), 32'({seconds, minutes}), 32'({6'd57, 6'd0}));
    end
    tick(I_STA);
    check("cd_resume_nostep", 32'({state, seconds}), 32'({2'd1, 6'd57}));
    tick(7'b0);
    check("cd_resume_step", 32'({seconds, minutes}), 32'({6'd56, 6'd0}));

    // Clear mid-run at 12:34.
    tick(I_RST);
    for (int i = 0; i < 34; i++) tick(I_SEC | ((i < 12) ? I_MIN : 7'b0));
    tick(I_STA);
    check("clr_preset", 32'({state, seconds, minutes}), 32'({2'd1, 6'd34, 6'd12}));
    tick(I_CLR);
    check("clr_mid_run", 32'(dut_vec), 32'd0);

    // Reset in the middle of DONE.
    tick(I_RST);
    tick(I_SEC);
    tick(I_STA);
    tick(7'b0);
    check("done_entry", 32'({state, running, finish, alarm}), 32'({2'd3, 3'b011}));
    tick(7'b0);
    tick(I_RST);
    check("reset_mid_done", 32'(dut_vec), 32'd0);

    // Random stimulus against the model.
    tick(I_RST);
    for (int i = 0; i < 3000; i++) begin
      r = 7'b0;
      if ($urandom_range(199) == 0) r |= I_RST;
      if ($urandom_range(39) == 0)  r |= I_CLR;
      if ($urandom_range(9) == 0)   r |= I_STP;
      if ($urandom_range(5) == 0)   r |= I_STA;
      if ($urandom_range(1) == 0)   r |= I_MD;
      if ($urandom_range(3) == 0)   r |= I_SEC;
      if ($urandom_range(3) == 0)   r |= I_MIN;
      tick(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
